seg7_step_monitor: RTL and testbench

Receive-side counterpart of the up/down counter's 7-segment output. It samples a 7-segment pattern bus, decodes it back to a 4-bit hex digit, and tracks successive digits. From that history it reports count direction, counts legal ±1 steps, and flags illegal patterns or jumps. It sits beside the counter on-board or in a bench as a self-checking monitor of the display path.

---
 rtl/seg7_step_monitor.sv | 147 ++++++++++++++
 tb/tb_seg7_step_monitor.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_step_monitor.sv
// seg7_step_monitor: decodes a sampled 7-segment bus back to a hex digit and
// tracks step direction, legal +/-1 step count and a sticky error flag.
// Optional feature macro: SEG7_MON_BLANK_EN (all-segments-off is a legal blank).
module seg7_step_monitor #(
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       seg_in,
    input  logic             sample_en,
    input  logic             err_clr,
    output logic [3:0]       digit,
    output logic             digit_valid,
    output logic [1:0]       dir,
    output logic [CNT_W-1:0] step_cnt,
    output logic             err
);

    typedef enum logic {
        EMPTY  = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [1:0] DIR_HOLD = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;
    localparam logic [1:0] DIR_JUMP = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_n;
    logic [6:0]       seg_fix;
    logic             legal;
    logic             blank;
    logic [3:0]       value;
    logic [3:0]       digit_up;
    logic [3:0]       digit_dn;
    logic [3:0]       digit_n;
    logic             valid_n;
    logic [1:0]       dir_n;
    logic [CNT_W-1:0] cnt_n;
    logic             cnt_inc;
    logic             err_set;
    logic             err_n;

    assign seg_fix  = SEG_ACTIVE_LOW ? ~seg_in : seg_in;
    assign digit_up = digit + 4'd1;
    assign digit_dn = digit - 4'd1;

`ifdef SEG7_MON_BLANK_EN
    assign blank = (seg_fix == 7'h00);
`else
    assign blank = 1'b0;
`endif

    // Pattern decode: map a polarity-corrected segment word to its hex digit.
    always_comb begin
        legal = 1'b1;
        value = 4'h0;
        case (seg_fix)
            7'h7E: value = 4'h0;
            7'h30: value = 4'h1;
            7'h6D: value = 4'h2;
            7'h79: value = 4'h3;
            7'h33: value = 4'h4;
            7'h5B: value = 4'h5;
            7'h5F: value = 4'h6;
            7'h70: value = 4'h7;
            7'h7F: value = 4'h8;
            7'h7B: value = 4'h9;
            7'h77: value = 4'hA;
            7'h1F: value = 4'hB;
            7'h4E: value = 4'hC;
            7'h3D: value = 4'hD;
            7'h4F: value = 4'hE;
            7'h47: value = 4'hF;
            default: legal = 1'b0;
        endcase
    end

    // Next-state and next-output logic; dir only reports on a sampled edge.
    always_comb begin
        state_n = state;
        digit_n = digit;
        valid_n = digit_valid;
        dir_n   = DIR_HOLD;
        cnt_inc = 1'b0;
        err_set = 1'b0;
        if (sample_en) begin
            if (blank) begin
                valid_n = 1'b0;
            end else if (!legal) begin
                valid_n = 1'b0;
                err_set = 1'b1;
                state_n = EMPTY;
            end else begin
                valid_n = 1'b1;
                digit_n = value;
                state_n = LOCKED;
                if (state == LOCKED) begin
                    if (value == digit_up) begin
                        dir_n   = DIR_UP;
                        cnt_inc = 1'b1;
                    end else if (value == digit_dn) begin
                        dir_n   = DIR_DOWN;
                        cnt_inc = 1'b1;
                    end else if (value != digit) begin
                        dir_n   = DIR_JUMP;
                        err_set = 1'b1;
                    end
                end
            end
        end
        cnt_n = (cnt_inc && step_cnt != CNT_MAX) ? step_cnt + CNT_ONE : step_cnt;
        // A new error on the same edge as a clear must stay visible.
        if (err_set) begin
            err_n = 1'b1;
        end else if (err_clr) begin
            err_n = 1'b0;
        end else begin
            err_n = err;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= EMPTY;
            digit       <= 4'h0;
            digit_valid <= 1'b0;
            dir         <= DIR_HOLD;
            step_cnt    <= '0;
            err         <= 1'b0;
        end else begin
            state       <= state_n;
            digit       <= digit_n;
            digit_valid <= valid_n;
            dir         <= dir_n;
            step_cnt    <= cnt_n;
            err         <= err_n;
        end
    end

endmodule

// File: tb/tb_seg7_step_monitor.sv
// tb_seg7_step_monitor: scoreboard bench driving an active-high and an
// active-low monitor with the same digit stream and comparing both.
module tb_seg7_step_monitor;

    typedef struct packed {
        logic [3:0] digit;
        logic       valid;
        logic [1:0] dir;
        logic [7:0] cnt;
        logic       err;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       sample_en;
    logic       err_clr;
    logic [6:0] seg;
    logic [6:0] seg_n;

    logic [3:0] digit_h, digit_l;
    logic       valid_h, valid_l;
    logic [1:0] dir_h, dir_l;
    logic [7:0] cnt_h, cnt_l;
    logic       err_h, err_l;

    obs_t exp_q[$];
    obs_t hi_q[$];
    obs_t lo_q[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign seg_n = ~seg;

    seg7_step_monitor #(.SEG_ACTIVE_LOW(1'b0), .CNT_W(8)) dut_hi (
        .clk(clk), .reset(reset), .seg_in(seg), .sample_en(sample_en),
        .err_clr(err_clr), .digit(digit_h), .digit_valid(valid_h),
        .dir(dir_h), .step_cnt(cnt_h), .err(err_h)
    );

    seg7_step_monitor #(.SEG_ACTIVE_LOW(1'b1), .CNT_W(8)) dut_lo (
        .clk(clk), .reset(reset), .seg_in(seg_n), .sample_en(sample_en),
        .err_clr(err_clr), .digit(digit_l), .digit_valid(valid_l),
        .dir(dir_l), .step_cnt(cnt_l), .err(err_l)
    );

    // Drive one edge, push the expected result, capture both DUTs after it.
    task automatic drive(input logic rv, input logic en, input logic clr,
                         input logic [6:0] s, input logic [3:0] d,
                         input logic v, input logic [1:0] dr,
                         input int c, input logic e);
        obs_t x;
        @(negedge clk);
        reset = rv; sample_en = en; err_clr = clr; seg = s;
        x.digit = d; x.valid = v; x.dir = dr; x.cnt = 8'(c); x.err = e;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        hi_q.push_back({digit_h, valid_h, dir_h, cnt_h, err_h});
        lo_q.push_back({digit_l, valid_l, dir_l, cnt_l, err_l});
    endtask

    task automatic test_reset();
        obs_t x, h, l;
        drive(0, 0, 0, 7'h00, 4'h0, 0, 2'b00, 0, 0);
        drive(0, 0, 0, 7'h00, 4'h0, 0, 2'b00, 0, 0);
        drive(0, 1, 1, 7'h30, 4'h0, 0, 2'b00, 0, 0);
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front(); h = hi_q.pop_front(); l = lo_q.pop_front();
            checks++;
            if (h !== x) begin errors++; $display("FAIL reset hi: got %h want %h", h, x); end
            checks++;
            if (l !== x) begin errors++; $display("FAIL reset lo: got %h want %h", l, x); end
        end
    endtask

    task automatic test_count_up();
        obs_t x, h, l;
        drive(1, 1, 0, 7'h7E, 4'h0, 1, 2'b00, 0, 0);
        drive(1, 1, 0, 7'h30, 4'h1, 1, 2'b01, 1, 0);
        drive(1, 1, 0, 7'h6D, 4'h2, 1, 2'b01, 2, 0);
        drive(1, 1, 0, 7'h79, 4'h3, 1, 2'b01, 3, 0);
        drive(1, 0, 0, 7'h30, 4'h3, 1, 2'b00, 3, 0);
        drive(1, 1, 0, 7'h79, 4'h3, 1, 2'b00, 3, 0);
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front(); h = hi_q.pop_front(); l = lo_q.pop_front();
            checks++;
            if (h !== x) begin errors++; $display("FAIL count_up hi: got %h want %h", h, x); end
            checks++;
            if (l !== x) begin errors++; $display("FAIL count_up lo: got %h want %h", l, x); end
        end
    endtask

    task automatic test_wrap();
        obs_t x, h, l;
        drive(1, 1, 0, 7'h6D, 4'h2, 1, 2'b10, 4, 0);
        drive(1, 1, 0, 7'h30, 4'h1, 1, 2'b10, 5, 0);
        drive(1, 1, 0, 7'h7E, 4'h0, 1, 2'b10, 6, 0);
        drive(1, 1, 0, 7'h47, 4'hF, 1, 2'b10, 7, 0);
        drive(1, 1, 0, 7'h7E, 4'h0, 1, 2'b01, 8, 0);
        drive(1, 1, 0, 7'h47, 4'hF, 1, 2'b10, 9, 0);
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front(); h = hi_q.pop_front(); l = lo_q.pop_front();
            checks++;
            if (h !== x) begin errors++; $display("FAIL wrap hi: got %h want %h", h, x); end
            checks++;
            if (l !== x) begin errors++; $display("FAIL wrap lo: got %h want %h", l, x); end
        end
    endtask

    task automatic test_jump();
        obs_t x, h, l;
        drive(1, 1, 0, 7'h7E, 4'h0, 1, 2'b01, 10, 0);
        drive(1, 1, 0, 7'h30, 4'h1, 1, 2'b01, 11, 0);
        drive(1, 1, 0, 7'h6D, 4'h2, 1, 2'b01, 12, 0);
        drive(1, 1, 0, 7'h7F, 4'h8, 1, 2'b11, 12, 1);
        drive(1, 0, 1, 7'h7F, 4'h8, 1, 2'b00, 12, 0);
        drive(1, 1, 1, 7'h79, 4'h3, 1, 2'b11, 12, 1);
        drive(1, 1, 1, 7'h79, 4'h3, 1, 2'b00, 12, 0);
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front(); h = hi_q.pop_front(); l = lo_q.pop_front();
            checks++;
            if (h !== x) begin errors++; $display("FAIL jump hi: got %h want %h", h, x); end
            checks++;
            if (l !== x) begin errors++; $display("FAIL jump lo: got %h want %h", l, x); end
        end
    endtask

    task automatic test_illegal();
        obs_t x, h, l;
        drive(1, 1, 0, 7'h01, 4'h3, 0, 2'b00, 12, 1);
        drive(1, 1, 0, 7'h5B, 4'h5, 1, 2'b00, 12, 1);
        drive(1, 0, 1, 7'h5B, 4'h5, 1, 2'b00, 12, 0);
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front(); h = hi_q.pop_front(); l = lo_q.pop_front();
            checks++;
            if (h !== x) begin errors++; $display("FAIL illegal hi: got %h want %h", h, x); end
            checks++;
            if (l !== x) begin errors++; $display("FAIL illegal lo: got %h want %h", l, x); end
        end
    endtask

    task automatic test_blank();
        obs_t x, h, l;
        drive(1, 1, 0, 7'h33, 4'h4, 1, 2'b10, 13, 0);
        drive(1, 1, 0, 7'h79, 4'h3, 1, 2'b10, 14, 0);
        drive(1, 1, 0, 7'h6D, 4'h2, 1, 2'b10, 15, 0);
        drive(1, 1, 0, 7'h30, 4'h1, 1, 2'b10, 16, 0);
`ifdef SEG7_MON_BLANK_EN
        drive(1, 1, 0, 7'h00, 4'h1, 0, 2'b00, 16, 0);
        drive(1, 1, 0, 7'h6D, 4'h2, 1, 2'b01, 17, 0);
        drive(1, 0, 1, 7'h6D, 4'h2, 1, 2'b00, 17, 0);
`else
        drive(1, 1, 0, 7'h00, 4'h1, 0, 2'b00, 16, 1);
        drive(1, 1, 0, 7'h6D, 4'h2, 1, 2'b00, 16, 1);
        drive(1, 0, 1, 7'h6D, 4'h2, 1, 2'b00, 16, 0);
`endif
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front(); h = hi_q.pop_front(); l = lo_q.pop_front();
            checks++;
            if (h !== x) begin errors++; $display("FAIL blank hi: got %h want %h", h, x); end
            checks++;
            if (l !== x) begin errors++; $display("FAIL blank lo: got %h want %h", l, x); end
        end
    endtask

    task automatic test_reset_midrun();
        obs_t x, h, l;
        drive(0, 1, 0, 7'h77, 4'h0, 0, 2'b00, 0, 0);
        drive(1, 1, 0, 7'h77, 4'hA, 1, 2'b00, 0, 0);
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front(); h = hi_q.pop_front(); l = lo_q.pop_front();
            checks++;
            if (h !== x) begin errors++; $display("FAIL reset_midrun hi: got %h want %h", h, x); end
            checks++;
            if (l !== x) begin errors++; $display("FAIL reset_midrun lo: got %h want %h", l, x); end
        end
    endtask

    task automatic test_saturation();
        obs_t x, h, l;
        for (int i = 0; i < 262; i++) begin
            if (i % 2 == 0) begin
                drive(1, 1, 0, 7'h1F, 4'hB, 1, 2'b01, (i + 1 > 255) ? 255 : i + 1, 0);
            end else begin
                drive(1, 1, 0, 7'h77, 4'hA, 1, 2'b10, (i + 1 > 255) ? 255 : i + 1, 0);
            end
        end
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front(); h = hi_q.pop_front(); l = lo_q.pop_front();
            checks++;
            if (h !== x) begin errors++; $display("FAIL saturation hi: got %h want %h", h, x); end
            checks++;
            if (l !== x) begin errors++; $display("FAIL saturation lo: got %h want %h", l, x); end
        end
    endtask

    initial begin
        reset = 1'b0;
        sample_en = 1'b0;
        err_clr = 1'b0;
        seg = 7'h00;
        test_reset();
        test_count_up();
        test_wrap();
        test_jump();
        test_illegal();
        test_blank();
        test_reset_midrun();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
